// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-lane data memory: access size encodings,
// controller states, byte-enable generation and load extract/extend.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Byte lanes touched by an access of size sz at byte offset off.
  function automatic logic [3:0] byte_en(input size_e sz, input logic [1:0] off);
    logic [3:0] be;
    be = '0;
    case (sz)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = off[1] ? 4'b1100 : 4'b0011;
      SZ_W:    be = '1;
      default: be = '0;
    endcase
    return be;
  endfunction

  // Move the addressed lane(s) down to bit 0 and sign/zero-extend.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input size_e sz,
                                               input logic [1:0] off, input logic uns);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (sz)
      SZ_B:    res = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    res = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      SZ_W:    res = word;
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// DEPTH x 32 single-port synchronous RAM with four byte-write enables and a
// registered read port (read returns the pre-write contents on a same-edge write).
module dmem_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  input  logic          re,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-lane write and registered read of the addressed word.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_bytelane.sv
// Byte-addressed RV32 data memory with valid/ready request channel, one-cycle
// registered response, error flagging and an optional zero-fill sweep after reset.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses raise rsp_err
// instead of having their low offset bits forced to zero.
module data_mem_bytelane
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DEPTH      = 1024,
  parameter bit          INIT_CLEAR = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_e             state;
  logic [IDX_W-1:0]   cnt;
  size_e              size;
  logic [1:0]         off;
  logic               mis_err;
  logic [ADDR_W-1:0]  hi_bits;
  logic               err;
  logic               acc;
  logic [3:0]         be;
  logic [31:0]        lane_data;
  logic [IDX_W-1:0]   ram_addr;
  logic [3:0]         ram_we;
  logic [31:0]        ram_wdata;
  logic               ram_re;
  logic [31:0]        ram_rdata;
  logic               ld_q;
  size_e              sz_q;
  logic [1:0]         off_q;
  logic               uns_q;

  // Request decode: offset normalisation, range/size/misalign checks, lane data.
  always_comb begin
    size    = size_e'(req_size);
    hi_bits = req_addr >> (IDX_W + 2);
    mis_err = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    off     = req_addr[1:0];
    mis_err = ((size == SZ_H) && req_addr[0]) || ((size == SZ_W) && (req_addr[1:0] != 2'b00));
`else
    case (size)
      SZ_H:    off = {req_addr[1], 1'b0};
      SZ_W:    off = 2'b00;
      default: off = req_addr[1:0];
    endcase
`endif
    err = (|hi_bits) || (size == SZ_RSV) || mis_err;
    acc = req_valid && req_ready;
    be  = byte_en(size, off);
    // Replicating the right-aligned data across lanes lets the byte enables do the shift.
    case (size)
      SZ_B:    lane_data = {4{req_wdata[7:0]}};
      SZ_H:    lane_data = {2{req_wdata[15:0]}};
      default: lane_data = req_wdata;
    endcase
  end

  // RAM port: owned by the clear sweep in INIT, by accepted requests in RUN.
  always_comb begin
    ram_addr  = req_addr[IDX_W+1:2];
    ram_we    = '0;
    ram_wdata = lane_data;
    ram_re    = 1'b0;
    if (state == ST_INIT) begin
      ram_addr  = cnt;
      ram_we    = '1;
      ram_wdata = '0;
    end else if (acc && !err) begin
      ram_we = req_we ? be : 4'h0;
      ram_re = !req_we;
    end
  end

  dmem_ram #(
    .DEPTH (DEPTH),
    .AW    (IDX_W)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .re    (ram_re),
    .rdata (ram_rdata)
  );

  // Controller FSM: clear sweep over every word, then steady one-access-per-cycle service.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT_CLEAR ? ST_INIT : ST_RUN;
      cnt       <= '0;
      req_ready <= !INIT_CLEAR;
      init_done <= !INIT_CLEAR;
    end else begin
      case (state)
        ST_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == IDX_W'(DEPTH - 1)) begin
            state     <= ST_RUN;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end
        end
        default: begin
          req_ready <= 1'b1;
          init_done <= 1'b1;
        end
      endcase
    end
  end

  // Response register: one pulse per accepted request, load context for extraction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      ld_q      <= 1'b0;
      sz_q      <= SZ_B;
      off_q     <= '0;
      uns_q     <= 1'b0;
    end else begin
      rsp_valid <= acc;
      rsp_err   <= acc && err;
      ld_q      <= acc && !req_we && !err;
      if (acc) begin
        sz_q  <= size;
        off_q <= off;
        uns_q <= req_unsigned;
      end
    end
  end

  // Load data comes straight off the registered RAM output; zero otherwise.
  always_comb begin
    rsp_rdata = '0;
    if (ld_q) rsp_rdata = load_extract(ram_rdata, sz_q, off_q, uns_q);
  end

endmodule
